// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder
// Brief    : SPI target that emulates an 8-channel 12-bit ADC; the control
//            word selects the channel returned in the following frame.
// Revision : 1.0
// ============================================================================
module adc_spi_responder #(
   parameter int SYNC_STAGES   = 2,
   parameter int RESET_CHANNEL = 0
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        adc_sclk,
   input  logic        adc_cs_n,
   input  logic        adc_din,
   output logic        adc_dout,
   output logic        adc_dout_oe,
   input  logic [95:0] channel_data,
   output logic        frame_done,
   output logic        frame_error,
   output logic [2:0]  next_channel,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_WAIT_CS = 2'd2
   } state_t;

   localparam logic [2:0] c_fill_target   = 3'(SYNC_STAGES);
   localparam logic [2:0] c_reset_channel = 3'(RESET_CHANNEL);
   localparam logic [4:0] c_last_bit      = 5'd15;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_din_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;
   logic [2:0]             r_fill;
   logic                   r_armed;

   logic w_sclk_s, w_cs_s, w_din_s;
   logic w_sclk_fall, w_sclk_rise, w_cs_fall, w_cs_rise;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_word, w_word_nxt;
   logic [15:0] r_ctrl, w_ctrl_nxt;
   logic [4:0]  r_bit_cnt, w_cnt_nxt;
   logic        r_dout, w_dout_nxt;
   logic        r_oe, w_oe_nxt;
   logic        r_done, w_done_nxt;
   logic        r_error, w_error_nxt;
   logic [2:0]  r_next_ch, w_next_ch_nxt;
   logic [15:0] r_frame_count, w_count_nxt;

   logic [11:0] w_sample;
   logic [15:0] w_start_word;
   logic [15:0] w_shift_word;
   logic [15:0] w_shift_ctrl;
   logic        w_unused_bits;

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
   assign w_din_s  = r_din_sync[SYNC_STAGES-1];

   assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
   assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;
   assign w_cs_fall   = r_cs_prev & ~w_cs_s;
   assign w_cs_rise   = ~r_cs_prev & w_cs_s;

   // Arming waits until the chains hold real pin samples, so a cs_n that was
   // already low when reset released never looks like a fresh frame start.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sclk_sync <= '1;
         r_cs_sync   <= '1;
         r_din_sync  <= '0;
         r_sclk_prev <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_fill      <= 3'd0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
         r_sclk_prev <= w_sclk_s;
         r_cs_prev   <= w_cs_s;
         if (r_fill != c_fill_target) begin
            r_fill <= r_fill + 3'd1;
         end else if (w_cs_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_sample      = channel_data[32'(r_next_ch) * 12 +: 12];
   assign w_start_word  = {4'b0000, w_sample};
   assign w_shift_word  = {r_word[14:0], 1'b0};
   assign w_shift_ctrl  = {r_ctrl[14:0], w_din_s};
   assign w_unused_bits = r_ctrl[15] ^ r_word[15];

   always_comb begin
      w_state_nxt   = r_state;
      w_word_nxt    = r_word;
      w_ctrl_nxt    = r_ctrl;
      w_cnt_nxt     = r_bit_cnt;
      w_dout_nxt    = r_dout;
      w_oe_nxt      = r_oe;
      w_done_nxt    = 1'b0;
      w_error_nxt   = 1'b0;
      w_next_ch_nxt = r_next_ch;
      w_count_nxt   = r_frame_count;

      unique case (r_state)
         ST_IDLE: begin
            if (r_armed && w_cs_fall) begin
               w_word_nxt  = w_start_word;
               w_ctrl_nxt  = 16'd0;
               w_cnt_nxt   = 5'd0;
               w_oe_nxt    = 1'b1;
               w_dout_nxt  = w_start_word[15];
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // cs_n is tested first so a coincident sclk edge is dropped.
            if (w_cs_rise) begin
               w_error_nxt = 1'b1;
               w_oe_nxt    = 1'b0;
               w_dout_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (w_sclk_fall) begin
               w_word_nxt = w_shift_word;
               w_dout_nxt = w_shift_word[15];
            end else if (w_sclk_rise) begin
               w_ctrl_nxt = w_shift_ctrl;
               w_cnt_nxt  = r_bit_cnt + 5'd1;
               if (r_bit_cnt == c_last_bit) begin
                  // ADD2..ADD0 arrived on rising edges 3..5.
                  w_done_nxt    = 1'b1;
                  w_next_ch_nxt = w_shift_ctrl[13:11];
                  w_count_nxt   = r_frame_count + 16'd1;
                  w_dout_nxt    = 1'b0;
                  w_state_nxt   = ST_WAIT_CS;
               end
            end
         end
         ST_WAIT_CS: begin
            w_dout_nxt = 1'b0;
            if (w_cs_rise) begin
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state       <= ST_IDLE;
         r_word        <= 16'd0;
         r_ctrl        <= 16'd0;
         r_bit_cnt     <= 5'd0;
         r_dout        <= 1'b0;
         r_oe          <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_next_ch     <= c_reset_channel;
         r_frame_count <= 16'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_word        <= w_word_nxt;
         r_ctrl        <= w_ctrl_nxt;
         r_bit_cnt     <= w_cnt_nxt;
         r_dout        <= w_dout_nxt;
         r_oe          <= w_oe_nxt;
         r_done        <= w_done_nxt;
         r_error       <= w_error_nxt;
         r_next_ch     <= w_next_ch_nxt;
         r_frame_count <= w_count_nxt;
      end
   end

   assign adc_dout     = r_dout;
   assign adc_dout_oe  = r_oe;
   assign frame_done   = r_done;
   assign frame_error  = r_error;
   assign next_channel = r_next_ch;
   assign frame_count  = r_frame_count;

endmodule
`default_nettype wire
